tile_vga_controller: RTL

TILE_VGA_CONTROLLER -- requirements
Module: tile_vga_controller

---
 rtl/tile_vga_controller.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/tile_vga_controller.sv
`default_nettype none
// tile_vga_controller: VGA raster timing with tile-granular display-memory addressing.
// Revision 1.0 - initial release.
module tile_vga_controller #(
  parameter int                BLOCK_LOG2 = 5,
  parameter int                ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(12'hC00),
  parameter int                BPC        = 1,
  parameter int                MEM_LAT    = 1,
  parameter int                H_SYNC     = 96,
  parameter int                H_BACK     = 48,
  parameter int                H_ACTIVE   = 640,
  parameter int                H_FRONT    = 16,
  parameter int                V_SYNC     = 2,
  parameter int                V_BACK     = 33,
  parameter int                V_ACTIVE   = 480,
  parameter int                V_FRONT    = 10
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              iEN,
  input  logic [31:0]       pix_data,
  output logic [ADDR_W-1:0] ADDR,
  output logic              oHS,
  output logic              oVS,
  output logic              oBLANK_n,
  output logic [7:0]        r_data,
  output logic [7:0]        g_data,
  output logic [7:0]        b_data,
  output logic              frame_start
);
  localparam int c_h_total = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int c_v_total = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int c_hw      = $clog2(c_h_total);
  localparam int c_vw      = $clog2(c_v_total);
  localparam int c_lat     = MEM_LAT + 2;
  localparam int c_en_w    = c_lat - 1;

  localparam logic [c_hw-1:0]   c_h_last    = c_hw'(c_h_total - 1);
  localparam logic [c_hw-1:0]   c_h_sync    = c_hw'(H_SYNC);
  localparam logic [c_hw-1:0]   c_h_start   = c_hw'(H_SYNC + H_BACK);
  localparam logic [c_hw-1:0]   c_h_end     = c_hw'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [c_vw-1:0]   c_v_last    = c_vw'(c_v_total - 1);
  localparam logic [c_vw-1:0]   c_v_sync    = c_vw'(V_SYNC);
  localparam logic [c_vw-1:0]   c_v_start   = c_vw'(V_SYNC + V_BACK);
  localparam logic [c_vw-1:0]   c_v_end     = c_vw'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [c_vw-1:0]   c_tile_mask = c_vw'((1 << BLOCK_LOG2) - 1);
  localparam logic [ADDR_W-1:0] c_h_blocks  = ADDR_W'(H_ACTIVE >> BLOCK_LOG2);

  logic [c_hw-1:0]   r_h_cnt;
  logic [c_vw-1:0]   r_v_cnt;
  logic [ADDR_W-1:0] r_row_base;
  logic [c_lat-1:0]  r_hs_pipe;
  logic [c_lat-1:0]  r_vs_pipe;
  logic [c_lat-1:0]  r_act_pipe;
  logic [c_en_w-1:0] r_en_pipe;

  logic              w_hs;
  logic              w_vs;
  logic              w_h_act;
  logic              w_v_act;
  logic              w_act;
  logic [ADDR_W-1:0] w_col;
  logic              w_unused;

  // Fill 8 bits by repeating the stored bits, MSB first.
  function automatic logic [7:0] expand(input logic [BPC-1:0] c);
    logic [8*BPC-1:0] rep;
    rep = {8{c}};
    return 8'(rep >> (8*BPC - 8));
  endfunction

  assign w_hs     = (r_h_cnt >= c_h_sync);
  assign w_vs     = (r_v_cnt >= c_v_sync);
  assign w_h_act  = (r_h_cnt >= c_h_start) && (r_h_cnt < c_h_end);
  assign w_v_act  = (r_v_cnt >= c_v_start) && (r_v_cnt < c_v_end);
  assign w_act    = w_h_act && w_v_act;
  assign w_col    = ADDR_W'((r_h_cnt - c_h_start) >> BLOCK_LOG2);
  assign w_unused = ^pix_data[31:3*BPC];

  assign oHS      = r_hs_pipe[c_lat-1];
  assign oVS      = r_vs_pipe[c_lat-1];
  assign oBLANK_n = r_act_pipe[c_lat-1];

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == c_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // Row base tracks row*H_BLOCKS; it steps at the start of each tile row's first line.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_row_base  <= '0;
      ADDR        <= BASE_ADDR;
      frame_start <= 1'b0;
    end else begin
      frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
      if (r_h_cnt == '0) begin
        if (r_v_cnt == c_v_start) begin
          r_row_base <= '0;
        end else if (w_v_act && (((r_v_cnt - c_v_start) & c_tile_mask) == '0)) begin
          r_row_base <= r_row_base + c_h_blocks;
        end
      end
      ADDR <= w_act ? (BASE_ADDR + r_row_base + w_col) : BASE_ADDR;
    end
  end

  // Colour is gated by the stage that reaches the pins on the same edge.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_hs_pipe  <= '1;
      r_vs_pipe  <= '1;
      r_act_pipe <= '0;
      r_en_pipe  <= '0;
      r_data     <= '0;
      g_data     <= '0;
      b_data     <= '0;
    end else begin
      r_hs_pipe  <= {r_hs_pipe[c_lat-2:0], w_hs};
      r_vs_pipe  <= {r_vs_pipe[c_lat-2:0], w_vs};
      r_act_pipe <= {r_act_pipe[c_lat-2:0], w_act};
      r_en_pipe  <= c_en_w'({r_en_pipe, iEN});
      if (r_act_pipe[c_lat-2] && r_en_pipe[c_lat-2]) begin
        r_data <= expand(pix_data[BPC-1:0]);
        g_data <= expand(pix_data[2*BPC-1:BPC]);
        b_data <= expand(pix_data[3*BPC-1:2*BPC]);
      end else begin
        r_data <= '0;
        g_data <= '0;
        b_data <= '0;
      end
    end
  end

endmodule
`default_nettype wire
